// File: rtl/dm_result_checker.sv
// dm_result_checker
//
// Checks the result of the MIPS sum-of-squares program. On start it reads N
// from data memory, builds the golden sum 1^2 + ... + N^2 one term per cycle,
// reads the program's result word back and compares the low RES_W bits.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   start     request a check, sampled only while idle
//   rd_en     data memory read strobe
//   rd_addr   data memory word address
//   rd_data   read data, valid the cycle after rd_en
//   busy      high whenever a check is in progress
//   done      one-cycle pulse, results valid from this cycle on
//   pass      low RES_W bits of observed and expected agree
//   overflow  sticky: golden sum exceeded the signed RES_W maximum
//   expected  golden sum modulo 2^DATA_W
//   observed  word read from RESULT_ADDR
module dm_result_checker #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int N_ADDR      = 0,
  parameter int RESULT_ADDR = 1,
  parameter int N_W         = 16,
  parameter int RES_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              overflow,
  output logic [DATA_W-1:0] expected,
  output logic [DATA_W-1:0] observed
);

  // Largest positive value the program's signed result can hold.
  localparam logic [DATA_W-1:0] RES_MAX = DATA_W'((64'd1 << (RES_W - 1)) - 64'd1);

  typedef enum logic [2:0] {
    IDLE,
    RD_N,
    WAIT_N,
    ACC,
    RD_RES,
    WAIT_RES,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [N_W-1:0]    n;
  logic [N_W-1:0]    k;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;
  logic [DATA_W-1:0] sq;
  logic [2*N_W-1:0]  sq_full;

  // The square is formed at full 2*N_W precision and then fitted to the
  // accumulator width, so the sum wraps exactly like a DATA_W register.
  assign sq_full = {{N_W{1'b0}}, k} * {{N_W{1'b0}}, k};

  generate
    if (2 * N_W >= DATA_W) begin : g_sq_trunc
      assign sq = sq_full[DATA_W-1:0];
    end else begin : g_sq_ext
      assign sq = {{(DATA_W - 2 * N_W){1'b0}}, sq_full};
    end
  endgenerate

  assign acc_next = acc + sq;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. N is checked straight off the read port so an N of
  // zero skips the accumulate phase entirely; ACC exits on the cycle that
  // adds the n-th term, giving exactly n accumulate cycles.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = RD_N;
      RD_N:     state_next = WAIT_N;
      WAIT_N:   state_next = (rd_data[N_W-1:0] == '0) ? RD_RES : ACC;
      ACC:      if (k == n) state_next = RD_RES;
      RD_RES:   state_next = WAIT_RES;
      WAIT_RES: state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Moore outputs; the read address is parked at zero outside read states.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    busy    = (state != IDLE);
    done    = (state == DONE);
    case (state)
      RD_N: begin
        rd_en   = 1'b1;
        rd_addr = ADDR_W'(N_ADDR);
      end
      RD_RES: begin
        rd_en   = 1'b1;
        rd_addr = ADDR_W'(RESULT_ADDR);
      end
      default: ;
    endcase
  end

  // Datapath. Result registers are cleared only when a new check is
  // accepted, so they stay readable after done until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      n        <= '0;
      k        <= '0;
      acc      <= '0;
      pass     <= 1'b0;
      overflow <= 1'b0;
      expected <= '0;
      observed <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pass     <= 1'b0;
            overflow <= 1'b0;
            expected <= '0;
            observed <= '0;
          end
        end
        WAIT_N: begin
          n   <= rd_data[N_W-1:0];
          k   <= N_W'(1);
          acc <= '0;
        end
        ACC: begin
          acc <= acc_next;
          k   <= k + N_W'(1);
          if (acc_next > RES_MAX) overflow <= 1'b1;
        end
        WAIT_RES: begin
          observed <= rd_data;
          expected <= acc;
          pass     <= (rd_data[RES_W-1:0] == acc[RES_W-1:0]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dm_result_checker.md
# dm_result_checker

Hardware result checker for the MIPS sum-of-squares program. On `start` it reads the input N from data memory, computes the golden sum 1²+…+N² iteratively, then reads the program's result word back from data memory and compares the two. It attaches to a one-cycle-latency read port on the data memory, beside the core, and reports pass/fail plus a sticky overflow flag for results that exceed the program's signed result width.

## Interface
- `DATA_W`, 32: data memory word width.
- `ADDR_W`, 8: data memory word-address width.
- `N_ADDR`, 0: word address holding N.
- `RESULT_ADDR`, 1: word address holding the program's result.
- `N_W`, 16: significant bits of N; upper `rd_data` bits are ignored.
- `RES_W`, 16: signed width of the program's result, used for overflow and compare.

- `clk`  in  1  clock; everything updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  request a check; sampled only in IDLE.
- `rd_en`  out  1  data memory read strobe.
- `rd_addr`  out  ADDR_W  data memory read address.
- `rd_data`  in  DATA_W  read data; valid the cycle after `rd_en`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; results valid from this cycle on.
- `pass`  out  1  `observed[RES_W-1:0] == expected[RES_W-1:0]`.
- `overflow`  out  1  golden sum exceeded 2^(RES_W-1)-1.
- `expected`  out  DATA_W  golden sum, modulo 2^DATA_W.
- `observed`  out  DATA_W  word read from `RESULT_ADDR`.

## Operation
- States: IDLE, RD_N, WAIT_N, ACC, RD_RES, WAIT_RES, DONE.
- IDLE: if `start` is high, clear `pass`, `overflow`, `expected` and `observed`, then go to RD_N.
- RD_N: drive `rd_en`=1 and `rd_addr`=N_ADDR. Go to WAIT_N.
- WAIT_N: capture `n = rd_data[N_W-1:0]`, set `k`=1 and `acc`=0. Go to ACC, or to RD_RES if n==0.
- ACC: each cycle update `acc += k*k` and `k++`. `k*k` is computed at 2·N_W bits and zero-extended or truncated to DATA_W. Set `overflow` (sticky) if the new acc > 2^(RES_W-1)-1, compared unsigned at DATA_W. Go to RD_RES on the cycle where k==n, so ACC lasts exactly n cycles.
- RD_RES: drive `rd_en`=1 and `rd_addr`=RESULT_ADDR. Go to WAIT_RES.
- WAIT_RES: capture `observed = rd_data`, set `expected = acc`, and register `pass`. Go to DONE.
- DONE: `done`=1 for this one cycle. Go to IDLE.
- `rd_en` is 0, and `rd_addr` is 0, in every state except RD_N and RD_RES.
- `start` is ignored while `busy` is high. `start` held high through DONE re-arms the block in the following IDLE cycle.
- `pass`, `overflow`, `expected` and `observed` hold their values after DONE until the next accepted `start`.
- `acc` wraps modulo 2^DATA_W with no saturation.

## Timing
- Reset values: state IDLE; `rd_en`, `busy`, `done`, `pass` and `overflow` are 0; `rd_addr`, `expected` and `observed` are 0.
- Reset mid-operation, from any state: back to IDLE with all outputs at reset values on the next cycle. No `done` is produced for the aborted run.
- Latency: if `start` is sampled at edge e0, `done` is high in the cycle after edge e0+n+4, i.e. n+4 cycles after acceptance. For n==0 this is 4 cycles.
- `busy` rises the cycle after acceptance and falls the cycle after `done`.
- Read port: one outstanding read at a time. The memory must return `rd_data` exactly one cycle after `rd_en`.

## Test plan
- N=45, mem[1]=31395: `expected`=31395, `overflow`=0, `pass`=1. `done` 49 cycles after acceptance; exactly two `rd_en` pulses, at addresses 0 then 1.
- N=46, mem[1]=33511: `expected`=33511, `overflow`=1, `pass`=1. This is the first N that overflows 15 positive bits.
- N=0, mem[1]=0: no ACC cycles. `done` 4 cycles after acceptance, `expected`=0, `pass`=1, `overflow`=0.
- N=10, mem[1]=384: `expected`=385, `observed`=384, `pass`=0. Outputs hold until the next `start`.
- N=57, mem[1]=0x0001F785, with `rst` pulsed during ACC at k=20: no `done`, and outputs are 0 the cycle after reset. After a restart, a single `done` with `expected`=63365, `overflow`=1, `pass`=1 (only the low 16 bits are compared).
- N=3, mem[1]=14, `start` held high for 20 cycles: one `done` at cycle 7, a second run accepted the cycle after DONE, and `start` pulses during `busy` produce no extra runs.
